// File: rtl/trap_controller.sv
// Machine-mode trap/MRET sequencer: drains the pipe, commits mepc/mcause/mtval,
// then issues one redirect to mtvec (trap) or mepc (return).
module trap_controller #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  output logic            exc_ready_o,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_valid_i,
  input  logic            pipe_empty_i,
  output logic            flush_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic [11:0]     csr_sel_i,
  input  logic            csr_wr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_hit_o,
  output logic            busy_o
);

  // state    | meaning
  // IDLE     | waiting for a request; exc_ready pulses here before leaving
  // DRAIN    | flushing until pipe_empty or the drain timeout
  // COMMIT   | trap only: write mepc/mcause/mtval
  // REDIRECT | hold redirect_valid/redirect_pc until fetch accepts
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;

  localparam logic [11:0]     CSR_MTVEC  = 12'h305;
  localparam logic [11:0]     CSR_MEPC   = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE = 12'h342;
  localparam logic [11:0]     CSR_MTVAL  = 12'h343;
  localparam logic [3:0]      DRAIN_LAST = 4'(DRAIN_TIMEOUT - 1);
  localparam logic [XLEN-1:0] MTVEC_MASK = ~(XLEN'(3));
  localparam logic [XLEN-1:0] MEPC_MASK  = ~(XLEN'(1));

  state_e          state_q;
  logic            exc_ready_q, flush_q, redirect_valid_q, is_trap_q;
  logic [3:0]      drain_cnt_q;
  logic [XLEN-1:0] redirect_pc_q, cause_q, pc_q, tval_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic            drain_done_d;

  assign drain_done_d = pipe_empty_i || (drain_cnt_q >= DRAIN_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      exc_ready_q      <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      is_trap_q        <= 1'b0;
      drain_cnt_q      <= '0;
      redirect_pc_q    <= '0;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      mtvec_q          <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
    end else begin
      exc_ready_q <= 1'b0;

      if (csr_wr_i) begin
        case (csr_sel_i)
          CSR_MTVEC:  mtvec_q  <= csr_wdata_i & MTVEC_MASK;
          CSR_MEPC:   mepc_q   <= csr_wdata_i & MEPC_MASK;
          CSR_MCAUSE: mcause_q <= csr_wdata_i;
          CSR_MTVAL:  mtval_q  <= csr_wdata_i;
          default: ;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (exc_ready_q) begin
            state_q <= DRAIN;
            flush_q <= 1'b1;
          end else if (exc_valid_i || mret_valid_i) begin
            exc_ready_q <= 1'b1;
            is_trap_q   <= exc_valid_i;
            cause_q     <= exc_cause_i;
            pc_q        <= exc_pc_i;
            tval_q      <= exc_tval_i;
          end
        end
        DRAIN: begin
          if (drain_done_d) begin
            drain_cnt_q <= '0;
            if (is_trap_q) begin
              state_q <= COMMIT;
            end else begin
              state_q          <= REDIRECT;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= mepc_q;
            end
          end else if (drain_cnt_q != 4'hF) begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end
        COMMIT: begin
          // Placed after the CSR write decode so the hardware update wins.
          mepc_q           <= pc_q & MEPC_MASK;
          mcause_q         <= cause_q;
          mtval_q          <= tval_q;
          state_q          <= REDIRECT;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= mtvec_q;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    case (csr_sel_i)
      CSR_MTVEC:  begin csr_hit_o = 1'b1; csr_rdata_o = mtvec_q;  end
      CSR_MEPC:   begin csr_hit_o = 1'b1; csr_rdata_o = mepc_q;   end
      CSR_MCAUSE: begin csr_hit_o = 1'b1; csr_rdata_o = mcause_q; end
      CSR_MTVAL:  begin csr_hit_o = 1'b1; csr_rdata_o = mtval_q;  end
      default: ;
    endcase
  end

  assign exc_ready_o      = exc_ready_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign busy_o           = (state_q != IDLE);

endmodule
